serial_add_sub_ctrl: RTL

- Bit-serial adder/subtractor controller that shares one internal 1-bit full-adder cell across all bit positions.
- Latches two WIDTH-bit operands on a start handshake and sequences the cell LSB-first, one bit per clock.
- Accumulates the sum, carry-out and signed-overflow flags, then pulses done.
- Area-cheap alternative to the parallel adder/subtractor blocks in the same library.

---
 rtl/serial_add_sub_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/serial_add_sub_ctrl.sv
// serial_add_sub_ctrl
//   Bit-serial adder/subtractor. One 1-bit full-adder cell is stepped across
//   the operands LSB-first, one bit per clock. The result, carry-out and
//   signed-overflow flags are then published, and done pulses for one cycle.
//
// Ports
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : operation request, sampled only while idle
//   op     : 0 = a + b, 1 = a - b (sampled with start)
//   a, b   : WIDTH-bit operands (sampled with start)
//   busy   : high while an operation is running or completing
//   done   : one-cycle pulse, result valid
//   sum    : WIDTH-bit result, held until the next completion
//   cout   : carry out of MSB (subtract: 1 = no borrow)
//   ovf    : signed overflow (carry into MSB xor carry out of MSB)
module serial_add_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             s_bit;
  logic             c_next;
  logic             last_bit;

  // Shared full-adder cell operating on the current LSBs.
  assign s_bit    = a_reg[0] ^ b_reg[0] ^ carry;
  assign c_next   = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry) | (b_reg[0] & carry);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)    state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // a_reg doubles as the result shift register: each sum bit enters from the
  // MSB side into the position vacated by the right shift, so after WIDTH
  // steps a_reg holds the result LSB-aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b ^ {WIDTH{op}};
            carry <= op;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_reg <= {s_bit, a_reg[WIDTH-1:1]};
          b_reg <= b_reg >> 1;
          carry <= c_next;
          cnt   <= cnt + CNT_W'(1);
          if (last_bit) begin
            sum  <= {s_bit, a_reg[WIDTH-1:1]};
            cout <= c_next;
            // carry still holds the carry into the MSB on this step
            ovf  <= carry ^ c_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
